// File: rtl/mux_arb.sv
// mux_arb: two-input packet arbiter holding a grant from HEAD to TAIL with round-robin tie-break
module mux_arb #(
    parameter int TYPEW = 2,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ivalid_0,
    input  logic             ivalid_1,
    input  logic [TYPEW-1:0] itype_0,
    input  logic [TYPEW-1:0] itype_1,
    input  logic             oready,
    output logic [1:0]       sel,
    output logic             iready_0,
    output logic             iready_1,
    output logic             busy,
    output logic [CNTW-1:0]  flit_cnt,
    output logic             proto_err
);
    localparam logic [TYPEW-1:0] NONE = TYPEW'(0);
    localparam logic [TYPEW-1:0] HEAD = TYPEW'(1);
    localparam logic [TYPEW-1:0] DATA = TYPEW'(2);
    localparam logic [TYPEW-1:0] TAIL = TYPEW'(3);
    localparam logic [CNTW-1:0]  CNT_MAX = {CNTW{1'b1}};

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t            state, state_nxt;
    logic              ptr, ptr_nxt;
    logic [CNTW-1:0]   cnt_nxt;
    logic              err_nxt;
    logic              req_0, req_1, bad_0, bad_1;
    logic              g_valid, xfer;
    logic [TYPEW-1:0]  g_type;

    assign sel      = {state == GRANT1, state == GRANT0};
    assign busy     = state != IDLE;
    assign iready_0 = (state == GRANT0) & oready;
    assign iready_1 = (state == GRANT1) & oready;

    assign req_0   = ivalid_0 & (itype_0 == HEAD);
    assign req_1   = ivalid_1 & (itype_1 == HEAD);
    assign bad_0   = ivalid_0 & ((itype_0 == DATA) | (itype_0 == TAIL));
    assign bad_1   = ivalid_1 & ((itype_1 == DATA) | (itype_1 == TAIL));
    assign g_valid = (state == GRANT1) ? ivalid_1 : ivalid_0;
    assign g_type  = (state == GRANT1) ? itype_1 : itype_0;
    assign xfer    = busy & g_valid & oready;

    // next-state, pointer, counter and error decode; only the granted port is observed while busy
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = flit_cnt;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                err_nxt = bad_0 | bad_1;
                if (req_0 && (!req_1 || !ptr)) begin
                    state_nxt = GRANT0;
                    ptr_nxt   = 1'b1;
                    cnt_nxt   = '0;
                end else if (req_1) begin
                    state_nxt = GRANT1;
                    ptr_nxt   = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            GRANT0, GRANT1: begin
                if (xfer && g_type != NONE && flit_cnt != CNT_MAX)
                    cnt_nxt = flit_cnt + CNTW'(1);
                err_nxt = xfer & (g_type == HEAD);
                if (xfer && g_type == TAIL)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register with asynchronous reset abandoning any grant silently
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            flit_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            flit_cnt  <= cnt_nxt;
            proto_err <= err_nxt;
        end
    end
endmodule
